// File: rtl/hazard3_aclint_mtimer.sv
// Multi-hart RISC-V machine timer and software-interrupt block on a 32-bit APB slave.
// One shared 64-bit mtime with prescaled tick input, per-hart mtimecmp and msip.
module hazard3_aclint_mtimer #(
  parameter int N_HARTS     = 1,
  parameter int TICK_IS_NRZ = 0,
  parameter int PRESCALE_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        paddr,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic               dbg_halt,
  input  logic               tick,
  output logic [N_HARTS-1:0] soft_irq,
  output logic [N_HARTS-1:0] timer_irq
);

  localparam logic [5:0] MSIP_LIMIT = 6'(N_HARTS);
  localparam logic [4:0] CMP_LIMIT  = 5'(N_HARTS);

  logic                  en;
  logic                  dbgstop;
  logic [PRESCALE_W-1:0] div;
  logic [PRESCALE_W-1:0] pcnt;
  logic [63:0]           mtime;
  logic [31:0]           mtimeh_shadow;
  logic [63:0]           mtimecmp [N_HARTS];
  logic [N_HARTS-1:0]    msip;

  logic       access, wr, rd;
  logic       hit_ctrl, hit_mtime, hit_mtimeh, hit_msip, hit_cmp, mapped;
  logic [3:0] msip_idx, cmp_idx;
  logic       tick_evt, qtick, mtime_inc;

  assign access = psel && penable;
  assign wr     = access && pwrite;
  assign rd     = access && !pwrite;

  assign hit_ctrl   = (paddr == 16'h0000);
  assign hit_mtime  = (paddr == 16'h0008);
  assign hit_mtimeh = (paddr == 16'h000c);
  // Hart slots beyond N_HARTS fail the index bound and fall through to the error response
  assign hit_msip   = (paddr[15:8] == 8'h01) && (paddr[1:0] == 2'b00) && (paddr[7:2] < MSIP_LIMIT);
  assign hit_cmp    = (paddr[15:8] == 8'h02) && (paddr[1:0] == 2'b00) && (paddr[7:3] < CMP_LIMIT);
  assign mapped     = hit_ctrl || hit_mtime || hit_mtimeh || hit_msip || hit_cmp;
  assign msip_idx   = paddr[5:2];
  assign cmp_idx    = paddr[6:3];

  assign pready  = 1'b1;
  assign pslverr = access && !mapped;

  generate
    if (TICK_IS_NRZ != 0) begin : g_nrz
      logic sync0, sync1, sync_prev;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync0     <= 1'b0;
          sync1     <= 1'b0;
          sync_prev <= 1'b0;
        end else begin
          sync0     <= tick;
          sync1     <= sync0;
          sync_prev <= sync1;
        end
      end
      assign tick_evt = sync1 ^ sync_prev;
    end else begin : g_level
      assign tick_evt = tick;
    end
  endgenerate

  assign qtick     = tick_evt && en && !(dbgstop && dbg_halt);
  assign mtime_inc = qtick && (pcnt == div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en      <= 1'b1;
      dbgstop <= 1'b1;
      div     <= '0;
      pcnt    <= '0;
    end else if (wr && hit_ctrl) begin
      en      <= pwdata[0];
      dbgstop <= pwdata[1];
      div     <= pwdata[8 +: PRESCALE_W];
      pcnt    <= '0;
    end else if (qtick) begin
      pcnt <= mtime_inc ? '0 : pcnt + 1'b1;
    end
  end

  // A bus write to one half wins over the increment and leaves the other half untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime         <= '0;
      mtimeh_shadow <= '0;
    end else begin
      if (wr && hit_mtime) begin
        mtime[31:0] <= pwdata;
      end else if (wr && hit_mtimeh) begin
        mtime[63:32] <= pwdata;
      end else if (mtime_inc) begin
        mtime <= mtime + 64'd1;
      end
      if (rd && hit_mtime) begin
        mtimeh_shadow <= mtime[63:32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msip      <= '0;
      timer_irq <= '0;
      for (int h = 0; h < N_HARTS; h++) begin
        mtimecmp[h] <= '1;
      end
    end else begin
      for (int h = 0; h < N_HARTS; h++) begin
        timer_irq[h] <= (mtime >= mtimecmp[h]);
        if (wr && hit_msip && (msip_idx == h[3:0])) begin
          msip[h] <= pwdata[0];
        end
        if (wr && hit_cmp && (cmp_idx == h[3:0])) begin
          if (paddr[2]) begin
            mtimecmp[h][63:32] <= pwdata;
          end else begin
            mtimecmp[h][31:0] <= pwdata;
          end
        end
      end
    end
  end

  assign soft_irq = msip;

  always_comb begin
    prdata = '0;
    if (access) begin
      if (hit_ctrl) begin
        prdata[0]               = en;
        prdata[1]               = dbgstop;
        prdata[8 +: PRESCALE_W] = div;
      end
      if (hit_mtime) begin
        prdata = mtime[31:0];
      end
      if (hit_mtimeh) begin
        prdata = mtimeh_shadow;
      end
      for (int h = 0; h < N_HARTS; h++) begin
        if (hit_msip && (msip_idx == h[3:0])) begin
          prdata = {31'd0, msip[h]};
        end
        if (hit_cmp && (cmp_idx == h[3:0])) begin
          prdata = paddr[2] ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
        end
      end
    end
  end

endmodule
